pkt_rx_responder: RTL and testbench

//  Responder (far) end of the packet-buffer send protocol (req/ack, rdy, wr, bop/eop).

---
 rtl/pkt_rx_responder_pkg.sv | 33 +++
 rtl/pkt_rx_responder_if.sv | 29 ++
 rtl/pkt_rx_responder_fifo.sv | 49 ++++
 rtl/pkt_rx_responder.sv | 115 +++++++++++
 tb/tb_pkt_rx_responder.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_rx_responder_pkg.sv
// Shared protocol constants, FSM encoding and record types for the packet receive responder.
package pkt_rx_responder_pkg;
    localparam logic [7:0] CTRL_HDR  = 8'hFF;
    localparam logic [7:0] CTRL_DATA = 8'h00;
    localparam logic [7:0] CTRL_LAST = 8'h80;

    localparam int DATA_W  = 64;
    localparam int ROUTE_W = 24;
    localparam int NBR_W   = 2;
    localparam int ENTRY_W = DATA_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RECV     = 2'd1,
        ST_WAIT_REL = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic              bop;
        logic              eop;
        logic [DATA_W-1:0] data;
    } fifo_entry_t;

    typedef struct packed {
        logic               bypass;
        logic [NBR_W-1:0]   neighbor;
        logic [ROUTE_W-1:0] route;
    } route_hdr_t;

    function automatic logic [DATA_W-1:0] hdr_word(input route_hdr_t h);
        return {29'b0, h.bypass, h.neighbor, h.route, 8'b0};
    endfunction
endpackage

// File: rtl/pkt_rx_responder_if.sv
// Sender-side handshake plus downstream ctrl-tagged stream; slave is the responder.
interface pkt_rx_responder_if;
    import pkt_rx_responder_pkg::*;

    logic               in_req;
    logic               in_ack;
    logic               in_rdy;
    logic               in_wr;
    logic [DATA_W-1:0]  in_data;
    logic               in_bop;
    logic               in_eop;
    logic [ROUTE_W-1:0] in_pkt_route;
    logic [NBR_W-1:0]   in_neighbor;
    logic               in_bypass;
    logic [DATA_W-1:0]  out_data;
    logic [7:0]         out_ctrl;
    logic               out_wr;
    logic               out_rdy;

    modport master (
        output in_req, in_wr, in_data, in_bop, in_eop, in_pkt_route, in_neighbor, in_bypass, out_rdy,
        input  in_ack, in_rdy, out_data, out_ctrl, out_wr
    );

    modport slave (
        input  in_req, in_wr, in_data, in_bop, in_eop, in_pkt_route, in_neighbor, in_bypass, out_rdy,
        output in_ack, in_rdy, out_data, out_ctrl, out_wr
    );
endinterface

// File: rtl/pkt_rx_responder_fifo.sv
// Show-ahead synchronous FIFO; storage has no reset so it can map onto block RAM.
module pkt_fifo_sync #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/pkt_rx_responder.sv
// Far end of the packet-buffer send protocol: grants a sender, buffers its packet,
// and re-emits it downstream as one header word followed by the payload words.
module pkt_rx_responder
    import pkt_rx_responder_pkg::*;
#(
    parameter int FIFO_DEPTH    = 256,
    parameter int MAX_PKT_WORDS = 128,
    parameter int RDY_SLACK     = 3
) (
    input  logic                clk,
    input  logic                reset,
    pkt_rx_responder_if.slave   rx,
    output logic                err_proto
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rx_state_t   state, state_nxt;
    logic [CW-1:0] count, free;
    logic        full, empty, push, pop, abort, wr_ok, bad_wr;
    logic        pkt_started, hdr_pending, hdr_sent, emit_hdr, emit_pay;
    fifo_entry_t push_data, head;
    route_hdr_t  hdr_q;
    logic        unused_bop;

    assign free        = CW'(FIFO_DEPTH) - count;
    assign rx.in_ack   = (state != ST_IDLE);
    assign rx.in_rdy   = (state == ST_RECV) && (free > CW'(RDY_SLACK));
    assign bad_wr      = rx.in_wr && !wr_ok;
    assign unused_bop  = head.bop;

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        wr_ok     = 1'b0;
        abort     = 1'b0;
        push_data = fifo_entry_t'{bop: rx.in_bop, eop: rx.in_eop, data: rx.in_data};
        case (state)
            ST_IDLE: begin
                if (rx.in_req && free >= CW'(MAX_PKT_WORDS) && !hdr_pending) state_nxt = ST_RECV;
            end
            ST_RECV: begin
                if (!rx.in_req) begin
                    // Sender gave up mid-packet: close the downstream frame with an empty last word.
                    abort     = 1'b1;
                    push      = pkt_started;
                    push_data = fifo_entry_t'{bop: 1'b0, eop: 1'b1, data: '0};
                    state_nxt = ST_IDLE;
                end else begin
                    wr_ok = rx.in_wr && !full;
                    push  = wr_ok;
                    if (rx.in_wr && rx.in_eop) state_nxt = ST_WAIT_REL;
                end
            end
            ST_WAIT_REL: begin
                if (!rx.in_req) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A new header waits until the previous packet's payload has drained through its eop.
    assign emit_hdr = hdr_pending && !hdr_sent && rx.out_rdy;
    assign emit_pay = !emit_hdr && hdr_sent && !empty && rx.out_rdy;
    assign pop      = emit_pay;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr_q       <= '0;
            hdr_pending <= 1'b0;
            hdr_sent    <= 1'b0;
            pkt_started <= 1'b0;
            err_proto   <= 1'b0;
            rx.out_wr   <= 1'b0;
            rx.out_data <= '0;
            rx.out_ctrl <= '0;
        end else begin
            rx.out_wr <= emit_hdr || emit_pay;
            if (emit_hdr) begin
                rx.out_data <= hdr_word(hdr_q);
                rx.out_ctrl <= CTRL_HDR;
                hdr_pending <= 1'b0;
                hdr_sent    <= 1'b1;
            end else if (emit_pay) begin
                rx.out_data <= head.data;
                rx.out_ctrl <= head.eop ? CTRL_LAST : CTRL_DATA;
                if (head.eop) hdr_sent <= 1'b0;
            end
            if (wr_ok && rx.in_bop) begin
                hdr_q       <= route_hdr_t'{bypass: rx.in_bypass, neighbor: rx.in_neighbor,
                                            route: rx.in_pkt_route};
                hdr_pending <= 1'b1;
                pkt_started <= 1'b1;
            end
            if (state_nxt != ST_RECV) pkt_started <= 1'b0;
            if (bad_wr || abort)      err_proto   <= 1'b1;
        end
    end

    pkt_fifo_sync #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );
endmodule

// File: tb/tb_pkt_rx_responder.sv
// Bench for pkt_rx_responder: vector table of packets on a full-size instance, plus
// a small-FIFO instance for back-pressure, and hand sequences for abort and reset.
module tb_pkt_rx_responder;
    typedef struct {
        logic [7:0]  ctrl;
        logic [63:0] data;
    } exp_t;

    typedef struct {
        int          len;
        logic [23:0] route;
        logic [1:0]  nbr;
        logic        byp;
        int          abort_after;
        bit          idle_wr;
        bit          rnd_rdy;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic err_a, err_b;
    exp_t qa[$];
    exp_t qb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   b_seen = 1'b0;
    bit   a_rand = 1'b0;
    vec_t vt[6];

    always #5 clk = ~clk;

    pkt_rx_responder_if a();
    pkt_rx_responder_if b();

    pkt_rx_responder dut_a (.clk(clk), .reset(reset), .rx(a), .err_proto(err_a));
    pkt_rx_responder #(.FIFO_DEPTH(16), .MAX_PKT_WORDS(16), .RDY_SLACK(3)) dut_b (
        .clk(clk), .reset(reset), .rx(b), .err_proto(err_b));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        a.out_rdy = a_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!reset && a.out_wr === 1'b1) begin
            if (qa.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL a_unexpected: got ctrl %0h data %0h, expected no word", a.out_ctrl, a.out_data);
            end else begin
                e = qa.pop_front();
                check("a_ctrl", {56'b0, a.out_ctrl}, {56'b0, e.ctrl});
                check("a_data", a.out_data, e.data);
            end
        end
    end

    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!reset && b.out_wr === 1'b1) begin
            b_seen = 1'b1;
            if (qb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL b_unexpected: got ctrl %0h data %0h, expected no word", b.out_ctrl, b.out_data);
            end else begin
                e = qb.pop_front();
                check("b_ctrl", {56'b0, b.out_ctrl}, {56'b0, e.ctrl});
                check("b_data", b.out_data, e.data);
            end
        end
    end

    task automatic idle_inputs();
        a.in_req = 0; a.in_wr = 0; a.in_data = '0; a.in_bop = 0; a.in_eop = 0;
        a.in_pkt_route = '0; a.in_neighbor = '0; a.in_bypass = 0;
        b.in_req = 0; b.in_wr = 0; b.in_data = '0; b.in_bop = 0; b.in_eop = 0;
        b.in_pkt_route = '0; b.in_neighbor = '0; b.in_bypass = 0; b.out_rdy = 1;
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b1;
        idle_inputs();
        qa.delete();
        qb.delete();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic drain(input bit which);
        int n = 0;
        while ((which ? qb.size() : qa.size()) != 0 && n < 600) begin
            @(posedge clk);
            n++;
        end
        check(which ? "b_words_missing" : "a_words_missing", which ? qb.size() : qa.size(), 0);
        repeat (3) @(posedge clk);
    endtask

    // Zero-latency sender on instance a; optional idle write, abort and mid-packet reset.
    task automatic send_a(input int len, input logic [23:0] route, input logic [1:0] nbr,
                          input logic byp, input int abort_after, input bit idle_wr, input int rst_at);
        int n;
        logic [63:0] d;
        @(posedge clk); #1;
        if (idle_wr) begin
            a.in_wr = 1; a.in_bop = 1; a.in_eop = 1; a.in_data = 64'hDEAD;
            @(posedge clk); #1;
            a.in_wr = 0; a.in_bop = 0; a.in_eop = 0;
            check("idle_wr_err", err_a, 1);
        end
        a.in_req = 1; a.in_pkt_route = route; a.in_neighbor = nbr; a.in_bypass = byp;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!a.in_ack && n < 20);
        check("ack_latency", n, 1);
        if (!a.in_ack) begin a.in_req = 0; return; end
        for (int i = 0; i < len; i++) begin
            n = 0;
            while (!a.in_rdy && n < 50) begin @(posedge clk); #1; n++; end
            if (n == 50) check("in_rdy_timeout", a.in_rdy, 1);
            d = {8'hA5, route, 32'(i)};
            a.in_wr = 1; a.in_data = d; a.in_bop = (i == 0);
            a.in_eop = (i == len - 1) && (abort_after == 0);
            if (i == 0) qa.push_back(exp_t'{8'hFF, {29'b0, byp, nbr, route, 8'b0}});
            qa.push_back(exp_t'{a.in_eop ? 8'h80 : 8'h00, d});
            @(posedge clk); #1;
            if (rst_at != 0 && i == rst_at - 1) begin
                a.in_wr = 0; a.in_bop = 0; a.in_eop = 0;
                #1 reset = 1'b1;
                #1;
                check("rst_in_ack", a.in_ack, 0);
                check("rst_in_rdy", a.in_rdy, 0);
                check("rst_out_wr", a.out_wr, 0);
                check("rst_out_data", a.out_data, 0);
                check("rst_out_ctrl", a.out_ctrl, 0);
                check("rst_err", err_a, 0);
                qa.delete();
                a.in_req = 0;
                repeat (2) @(posedge clk);
                #2 reset = 1'b0;
                return;
            end
            if (abort_after != 0 && i == abort_after - 1) begin
                a.in_wr = 0; a.in_bop = 0; a.in_eop = 0; a.in_req = 0;
                qa.push_back(exp_t'{8'h80, 64'h0});
                @(posedge clk); #1;
                check("abort_err", err_a, 1);
                check("abort_ack", a.in_ack, 0);
                return;
            end
        end
        a.in_wr = 0; a.in_bop = 0; a.in_eop = 0;
        check("wait_rel_ack", a.in_ack, 1);
        check("wait_rel_rdy", a.in_rdy, 0);
        a.in_req = 0;
        @(posedge clk); #1;
        check("ack_release", a.in_ack, 0);
    endtask

    initial begin : main
        int n, ndec, nwr, cyc;
        logic [2:0] pipe;
        logic [63:0] d;

        vt[0] = '{4,  24'hABCDE1, 2'd2, 1'b1, 0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1,  24'h123456, 2'd1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
        vt[2] = '{10, 24'h0F0F0F, 2'd3, 1'b0, 5, 1'b0, 1'b0, 1'b1};
        vt[3] = '{3,  24'h777777, 2'd0, 1'b1, 0, 1'b1, 1'b0, 1'b1};
        vt[4] = '{12, 24'hFFFFFF, 2'd3, 1'b1, 0, 1'b0, 1'b1, 1'b0};
        vt[5] = '{2,  24'h000000, 2'd0, 1'b0, 0, 1'b0, 1'b1, 1'b0};

        idle_inputs();
        #1 reset = 1'b1;
        #1;
        check("reset_in_ack", a.in_ack, 0);
        check("reset_in_rdy", a.in_rdy, 0);
        check("reset_out_wr", a.out_wr, 0);
        check("reset_out_data", a.out_data, 0);
        check("reset_out_ctrl", a.out_ctrl, 0);
        check("reset_err", err_a, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        foreach (vt[k]) begin
            do_reset();
            a_rand = vt[k].rnd_rdy;
            send_a(vt[k].len, vt[k].route, vt[k].nbr, vt[k].byp, vt[k].abort_after, vt[k].idle_wr, 0);
            drain(1'b0);
            check("vec_err_proto", err_a, vt[k].exp_err);
            check("vec_idle_ack", a.in_ack, 0);
        end
        a_rand = 1'b0;

        // Reset while word 3 of 8 is in flight, then a clean packet.
        do_reset();
        send_a(8, 24'h314159, 2'd1, 1'b1, 0, 1'b0, 3);
        send_a(5, 24'h271828, 2'd2, 1'b0, 0, 1'b0, 0);
        drain(1'b0);
        check("post_reset_err", err_a, 0);

        // Back-pressure: 16-entry FIFO, stalled downstream, sender with 2-cycle write latency.
        do_reset();
        b.out_rdy = 0; b_seen = 1'b0;
        b.in_req = 1; b.in_pkt_route = 24'h5A5A5A; b.in_neighbor = 2'd1; b.in_bypass = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!b.in_ack && n < 20);
        check("b_ack", b.in_ack, 1);
        pipe = '0; ndec = 0; nwr = 0; cyc = 0;
        while (nwr < 20 && cyc < 400) begin
            if (cyc == 60) begin
                check("b_stall_rdy", b.in_rdy, 0);
                check("b_stall_fill", (nwr >= 13 && nwr <= 16), 1);
                check("b_stall_err", err_b, 0);
                check("b_no_out_while_blocked", b_seen, 0);
                b.out_rdy = 1;
            end
            pipe = {pipe[1:0], (ndec < 20) && b.in_rdy};
            if (pipe[0]) ndec++;
            if (pipe[2]) begin
                d = {16'hB00B, 16'h0, 32'(nwr)};
                b.in_wr = 1; b.in_data = d; b.in_bop = (nwr == 0); b.in_eop = (nwr == 19);
                if (nwr == 0) qb.push_back(exp_t'{8'hFF, {29'b0, 1'b0, 2'd1, 24'h5A5A5A, 8'b0}});
                qb.push_back(exp_t'{(nwr == 19) ? 8'h80 : 8'h00, d});
                nwr++;
            end else begin
                b.in_wr = 0; b.in_bop = 0; b.in_eop = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        b.in_wr = 0; b.in_bop = 0; b.in_eop = 0;
        check("b_all_written", nwr, 20);
        b.in_req = 0;
        drain(1'b1);
        check("b_err", err_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end
endmodule
